// File: rtl/stopwatch_control_fsm_if.sv
// stopwatch_control_fsm_if: KEY inputs and counter/display control outputs of the stopwatch sequencer.
interface stopwatch_control_fsm_if;
  logic       start_button;
  logic       stop_button;
  logic       lap_button;
  logic       clear_button;
  logic       tick;
  logic       count_clr;
  logic       display_hold;
  logic       running;
  logic [1:0] state;
  modport master (
    output start_button, stop_button, lap_button, clear_button,
    input  tick, count_clr, display_hold, running, state
  );
  modport slave (
    input  start_button, stop_button, lap_button, clear_button,
    output tick, count_clr, display_hold, running, state
  );
endinterface

// File: rtl/stopwatch_control_fsm.sv
// stopwatch_control_fsm: debounced KEY front end driving an IDLE/RUN/PAUSE/LAP sequencer and tick prescaler.
// Define STOPWATCH_LAP_EN to enable the lap button and the LAP state.
module stopwatch_control_fsm #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int TICK_DIV        = 500000
) (
  input logic                   clk,
  input logic                   rst_n,
  stopwatch_control_fsm_if.slave sw
);
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10, LAP = 2'b11} state_t;
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PW = $clog2(TICK_DIV);
`ifdef STOPWATCH_LAP_EN
  localparam int NB = 4;
`else
  localparam int NB = 3;
`endif
  logic [NB-1:0] btn, s1_q, s2_q, deb_q, prev_q, evt_q;
  logic [CW-1:0] cnt_q [NB];
  logic          sta_evt, stp_evt, clr_evt, lap_evt;
`ifdef STOPWATCH_LAP_EN
  assign btn     = {sw.lap_button, sw.clear_button, sw.stop_button, sw.start_button};
  assign lap_evt = evt_q[3];
`else
  logic unused_lap;
  assign btn        = {sw.clear_button, sw.stop_button, sw.start_button};
  assign lap_evt    = 1'b0;
  assign unused_lap = sw.lap_button;
`endif
  assign sta_evt = evt_q[0];
  assign stp_evt = evt_q[1];
  assign clr_evt = evt_q[2];
  // Level only changes after DEBOUNCE_CYCLES consecutive mismatching samples; evt fires on the debounced fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= '1;
      s2_q   <= '1;
      deb_q  <= '1;
      prev_q <= '1;
      evt_q  <= '0;
      for (int i = 0; i < NB; i++) cnt_q[i] <= '0;
    end else begin
      s1_q   <= btn;
      s2_q   <= s1_q;
      prev_q <= deb_q;
      evt_q  <= prev_q & ~deb_q;
      for (int i = 0; i < NB; i++) begin
        if (s2_q[i] == deb_q[i]) cnt_q[i] <= '0;
        else if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          cnt_q[i] <= '0;
          deb_q[i] <= s2_q[i];
        end else cnt_q[i] <= cnt_q[i] + CW'(1);
      end
    end
  end
  state_t        state_q, state_d;
  logic [PW-1:0] pre_q;
  logic          tick_q, clr_q, run, stopped, clear_ok, adv, wrap;
  assign run      = state_q == RUN || state_q == LAP;
  assign stopped  = state_q == IDLE || state_q == PAUSE;
  // Each branch tests its legal events in priority order, so lower-priority simultaneous events drop out.
  assign state_d  = stopped ? (clr_evt ? IDLE : sta_evt ? RUN : state_q)
                            : (stp_evt ? PAUSE : lap_evt ? (state_q == RUN ? LAP : RUN) : state_q);
  assign clear_ok = clr_evt && stopped;
  assign adv      = run && (state_d == RUN || state_d == LAP);
  assign wrap     = pre_q == PW'(TICK_DIV - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pre_q   <= '0;
      tick_q  <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      clr_q   <= clear_ok;
      tick_q  <= adv && wrap;
      pre_q   <= clear_ok ? '0 : !adv ? pre_q : wrap ? '0 : pre_q + PW'(1);
    end
  end
  assign sw.tick         = tick_q;
  assign sw.count_clr    = clr_q;
  assign sw.running      = run;
  assign sw.display_hold = state_q == LAP;
  assign sw.state        = state_q;
endmodule

// File: tb/tb_stopwatch_control_fsm.sv
// tb_stopwatch_control_fsm: directed checks of debounce latency, ticking, pause/resume, lap, clear priority and async reset.
module tb_stopwatch_control_fsm;
  localparam logic [3:0] START = 4'b0001, STOP = 4'b0010, LAP = 4'b0100, CLEAR = 4'b1000;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] btn_n = 4'hf;
  int         tests = 0, fails = 0, tick_cnt = 0, clr_cnt = 0, n0;
  stopwatch_control_fsm_if sw ();
  assign sw.start_button = btn_n[0];
  assign sw.stop_button  = btn_n[1];
  assign sw.lap_button   = btn_n[2];
  assign sw.clear_button = btn_n[3];
  stopwatch_control_fsm #(.DEBOUNCE_CYCLES(4), .TICK_DIV(5)) dut (.clk(clk), .rst_n(rst_n), .sw(sw));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    tick_cnt += int'(sw.tick);
    clr_cnt  += int'(sw.count_clr);
  end
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  // Pin falls just after an edge: event visible after edge 7, state updates on edge 8.
  task automatic press_chk(input logic [3:0] m, input logic [1:0] before_s, input logic [1:0] after_s, input string tag);
    btn_n = btn_n & ~m;
    step(7);
    chk({tag, "_before"}, 32'(sw.state), 32'(before_s));
    step(1);
    chk({tag, "_after"}, 32'(sw.state), 32'(after_s));
    step(2);
    btn_n = 4'hf;
    step(10);
  endtask
  task automatic wait_tick;
    int k = 0;
    step(1);
    while (sw.tick !== 1'b1 && k < 20) begin
      step(1);
      k++;
    end
    chk("wait_tick", 32'(sw.tick), 32'd1);
  endtask
  initial begin
    step(3);
    chk("rst_state", 32'(sw.state), 32'd0);
    chk("rst_running", 32'(sw.running), 32'd0);
    chk("rst_tick", 32'(sw.tick), 32'd0);
    chk("rst_count_clr", 32'(sw.count_clr), 32'd0);
    chk("rst_hold", 32'(sw.display_hold), 32'd0);
    rst_n = 1'b1;
    step(2);
    btn_n[0] = 1'b0;
    step(7);
    chk("start_before", 32'(sw.state), 32'd0);
    step(1);
    chk("start_run", 32'(sw.state), 32'd1);
    chk("start_running", 32'(sw.running), 32'd1);
    step(4);
    chk("tick_gap1", 32'(sw.tick), 32'd0);
    step(1);
    chk("tick_first", 32'(sw.tick), 32'd1);
    step(1);
    chk("tick_width", 32'(sw.tick), 32'd0);
    step(3);
    chk("tick_gap2", 32'(sw.tick), 32'd0);
    step(1);
    chk("tick_second", 32'(sw.tick), 32'd1);
    step(2);
    btn_n = 4'hf;
    chk("start_no_clr", 32'(clr_cnt), 32'd0);
    step(10);
    btn_n[1] = 1'b0;
    step(3);
    btn_n[1] = 1'b1;
    step(12);
    chk("glitch_ignored", 32'(sw.state), 32'd1);
    press_chk(CLEAR, 2'd1, 2'd1, "clear_in_run");
    chk("clear_in_run_clr", 32'(clr_cnt), 32'd0);
    wait_tick;
    step(1);
    press_chk(STOP, 2'd1, 2'd2, "pause");
    n0 = tick_cnt;
    step(50);
    chk("pause_no_ticks", 32'(tick_cnt - n0), 32'd0);
    chk("pause_state", 32'(sw.state), 32'd2);
    for (int i = 0; i < 3; i++) begin
      btn_n[0] = 1'b0;
      step(2);
      btn_n[0] = 1'b1;
      step(2);
    end
    chk("bounce_filtered", 32'(sw.state), 32'd2);
    btn_n[0] = 1'b0;
    step(7);
    chk("resume_before", 32'(sw.state), 32'd2);
    step(1);
    chk("resume_run", 32'(sw.state), 32'd1);
    chk("resume_tick0", 32'(sw.tick), 32'd0);
    step(1);
    chk("resume_tick1", 32'(sw.tick), 32'd0);
    step(1);
    chk("resume_tick2", 32'(sw.tick), 32'd1);
    step(2);
    btn_n = 4'hf;
    step(10);
`ifdef STOPWATCH_LAP_EN
    press_chk(LAP, 2'd1, 2'd3, "lap_in");
    chk("lap_hold", 32'(sw.display_hold), 32'd1);
    chk("lap_running", 32'(sw.running), 32'd1);
    n0 = tick_cnt;
    step(10);
    chk("lap_ticks", 32'(tick_cnt - n0), 32'd2);
    press_chk(LAP, 2'd3, 2'd1, "lap_out");
    chk("lap_out_hold", 32'(sw.display_hold), 32'd0);
    press_chk(LAP, 2'd1, 2'd3, "lap_again");
    wait_tick;
    step(1);
    press_chk(STOP, 2'd3, 2'd2, "lap_stop");
`else
    press_chk(LAP, 2'd1, 2'd1, "lap_ignored");
    chk("lap_ignored_hold", 32'(sw.display_hold), 32'd0);
    wait_tick;
    step(1);
    press_chk(STOP, 2'd1, 2'd2, "stop_again");
`endif
    chk("stopped_hold", 32'(sw.display_hold), 32'd0);
    chk("stopped_running", 32'(sw.running), 32'd0);
    n0 = clr_cnt;
    btn_n = btn_n & ~(CLEAR | START);
    step(7);
    chk("clr_start_before", 32'(sw.state), 32'd2);
    chk("clr_start_noclr", 32'(sw.count_clr), 32'd0);
    step(1);
    chk("clr_start_idle", 32'(sw.state), 32'd0);
    chk("clr_pulse", 32'(sw.count_clr), 32'd1);
    chk("clr_no_tick", 32'(sw.tick), 32'd0);
    step(1);
    chk("clr_pulse_end", 32'(sw.count_clr), 32'd0);
    chk("clr_start_dropped", 32'(sw.state), 32'd0);
    step(1);
    btn_n = 4'hf;
    step(10);
    chk("clr_single", 32'(clr_cnt - n0), 32'd1);
    btn_n[0] = 1'b0;
    step(8);
    chk("restart_run", 32'(sw.state), 32'd1);
    step(4);
    chk("prescaler_zeroed_gap", 32'(sw.tick), 32'd0);
    step(1);
    chk("prescaler_zeroed_tick", 32'(sw.tick), 32'd1);
    step(1);
    btn_n = 4'hf;
    step(10);
    press_chk(STOP | LAP, 2'd1, 2'd2, "stop_lap");
    chk("stop_lap_hold", 32'(sw.display_hold), 32'd0);
    press_chk(START, 2'd2, 2'd1, "run_again");
    wait_tick;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_state", 32'(sw.state), 32'd0);
    chk("async_rst_tick", 32'(sw.tick), 32'd0);
    chk("async_rst_running", 32'(sw.running), 32'd0);
    chk("async_rst_hold", 32'(sw.display_hold), 32'd0);
    chk("async_rst_clr", 32'(sw.count_clr), 32'd0);
    step(2);
    rst_n = 1'b1;
    step(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
